// File: rtl/dualport_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dualport_pkg
// Description : Shared defaults and types for the dualport memory slice.
//               DATA_W / ADDR_W are the default word and address widths,
//               DEPTH is the matching word count (2**ADDR_W).
//               The optional build macro DUALPORT_BYPASS_EN (used in dualport)
//               turns on write-to-read forwarding on same-address collisions.
// Revision    : 1.0 - initial release
// ============================================================================
package dualport_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage : dualport_pkg
`default_nettype wire

// File: rtl/dualport_regfile.sv
`default_nettype none
// ============================================================================
// Module      : dualport_regfile
// Description : 2**ADDR_W x DATA_W storage array with one synchronous write
//               port and one combinational read port.
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears every word
//   we    - write enable
//   wa    - write address
//   Din   - write data
//   ra    - read address
//   rdata - combinational contents of word ra (pre-write value this cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module dualport_regfile #(
    parameter int DATA_W = dualport_pkg::DATA_W,
    parameter int ADDR_W = dualport_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] Din,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rdata
);
    import dualport_pkg::*;

    localparam int c_depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_depth];

    // Reset wins over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[wa] <= Din;
        end
    end

    // Reads the array before this edge's write lands, which gives the
    // read-before-write behaviour on a same-address collision.
    assign rdata = r_mem[ra];

endmodule : dualport_regfile
`default_nettype wire

// File: rtl/dualport.sv
`default_nettype none
// ============================================================================
// Module      : dualport
// Description : Simple dual-port memory, one write port and one read port,
//               one-clock registered read latency.
//   clk  - clock, rising edge
//   Din  - write data
//   Dout - registered read data, holds while re=0
//   re   - read enable
//   we   - write enable
//   wa   - write address
//   ra   - read address
//   rst  - synchronous active-high reset (clears Dout and memory)
//   Build macro DUALPORT_BYPASS_EN: when defined, a same-cycle read and
//   write to the same address returns the new write data (write-first);
//   otherwise the old contents are returned (read-before-write).
// Revision    : 1.0 - initial release
// ============================================================================
module dualport #(
    parameter int DATA_W = dualport_pkg::DATA_W,
    parameter int ADDR_W = dualport_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic [DATA_W-1:0] Din,
    output logic [DATA_W-1:0] Dout,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [ADDR_W-1:0] ra,
    input  logic              rst
);
    import dualport_pkg::*;

    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_rd_value;
    logic [DATA_W-1:0] r_dout;

    dualport_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .wa    (wa),
        .Din   (Din),
        .ra    (ra),
        .rdata (w_rdata)
    );

`ifdef DUALPORT_BYPASS_EN
    // Forward the incoming write data when it targets the word being read.
    assign w_rd_value = (we && (ra == wa)) ? Din : w_rdata;
`else
    assign w_rd_value = w_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (re) begin
            r_dout <= w_rd_value;
        end
    end

    assign Dout = r_dout;

endmodule : dualport
`default_nettype wire

// File: tb/tb_dualport.sv
`default_nettype none
// ============================================================================
// Module      : tb_dualport
// Description : Self-checking bench for dualport. A behavioural memory model
//               (plain array plus expected read register) tracks every edge;
//               Dout is compared against it on every falling edge, and the
//               directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dualport;

    logic       clk = 1'b0;
    logic [7:0] Din = '0;
    logic [7:0] Dout;
    logic       re  = 1'b0;
    logic       we  = 1'b0;
    logic [3:0] wa  = '0;
    logic [3:0] ra  = '0;
    logic       rst = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_mem [16];
    logic [7:0] m_dout;
    bit         chk_en = 1'b0;

`ifdef DUALPORT_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    always #5 clk = ~clk;

    dualport u_dut (
        .clk  (clk),
        .Din  (Din),
        .Dout (Dout),
        .re   (re),
        .we   (we),
        .wa   (wa),
        .ra   (ra),
        .rst  (rst)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) chk("dout_vs_model", Dout, m_dout);
    end

    // Drive one cycle; the model is advanced from the values held across the edge.
    task automatic cyc(input logic r, input logic w, input logic [3:0] a_w,
                       input logic [7:0] d, input logic rd, input logic [3:0] a_r);
        logic [7:0] nxt;
        rst = r; we = w; wa = a_w; Din = d; re = rd; ra = a_r;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
            m_dout = 8'h00;
        end else begin
            if (rd) begin
                nxt = (c_bypass && w && (a_r == a_w)) ? d : m_mem[a_r];
                m_dout = nxt;
            end
            if (w) m_mem[a_w] = d;
        end
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b1, a, d, 1'b0, 4'h0);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, a);
    endtask

    initial begin
        logic [7:0] held;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_dout = 8'h00;

        // Power-up reset.
        cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        chk_en = 1'b1;
        chk("reset_dout", Dout, 8'h00);

        // Random writes, then reset clears everything.
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom_range(1, 255)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        for (int j = 0; j < 16; j++) begin
            rd(4'(j));
            chk("reset_clear", Dout, 8'h00);
        end

        // Fill and read back.
        for (int i = 0; i < 16; i++) wr(4'(i), 8'(i + 8'h40));
        for (int j = 0; j < 16; j++) begin
            rd(4'(j));
            chk("fill_readback", Dout, 8'(j + 8'h40));
        end

        // Overlapped streams after a clearing reset: read trails write by one.
        cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        wr(4'h0, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, (k < 16), 4'(k), 8'(k), 1'b1, 4'(k - 1));
            chk("overlap_stream", Dout, 8'(k - 1));
        end

        // Same-address collision.
        wr(4'h5, 8'hA5);
        cyc(1'b0, 1'b1, 4'h5, 8'h3C, 1'b1, 4'h5);
`ifdef DUALPORT_BYPASS_EN
        chk("collision", Dout, 8'h3C);
        chk("model_pin_collision", m_dout, 8'h3C);
`else
        chk("collision", Dout, 8'hA5);
        chk("model_pin_collision", m_dout, 8'hA5);
`endif
        rd(4'h5);
        chk("post_collision_read", Dout, 8'h3C);
        chk("model_pin_post", m_dout, 8'h3C);

        // Hold: re=0 for three cycles while other traffic moves.
        held = Dout;
        cyc(1'b0, 1'b1, 4'h9, 8'h11, 1'b0, 4'h9);
        cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h3);
        cyc(1'b0, 1'b1, 4'h5, 8'h22, 1'b0, 4'h5);
        chk("hold", Dout, held);
        chk("hold_literal", Dout, 8'h3C);

        // Reset priority over a write.
        wr(4'h2, 8'h77);
        cyc(1'b1, 1'b1, 4'h2, 8'hFF, 1'b1, 4'h2);
        chk("reset_priority_dout", Dout, 8'h00);
        rd(4'h2);
        chk("reset_discards_write", Dout, 8'h00);
        chk("model_pin_reset", m_dout, 8'h00);

        // Randomized traffic with frequent same-address collisions.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] a_w;
            logic [3:0] a_r;
            a_w = 4'($urandom_range(0, 15));
            a_r = ($urandom_range(0, 3) == 0) ? a_w : 4'($urandom_range(0, 15));
            cyc(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)), a_w,
                8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), a_r);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dualport
`default_nettype wire
